// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters, the shared memory and memory_arbiter.
// Requester A/B: request, write_enable, address, write_data in; ack, read_data out.
// Memory side: write_enable, address, write_data out; read_data in. busy out.
// The master modport is the environment view, slave is the arbiter view.
interface memory_arbiter_if;
  localparam int unsigned DATA_W = 16;

  logic              a_request;
  logic              a_write_enable;
  logic [DATA_W-1:0] a_address;
  logic [DATA_W-1:0] a_write_data;
  logic              a_ack;
  logic [DATA_W-1:0] a_read_data;

  logic              b_request;
  logic              b_write_enable;
  logic [DATA_W-1:0] b_address;
  logic [DATA_W-1:0] b_write_data;
  logic              b_ack;
  logic [DATA_W-1:0] b_read_data;

  logic              memory_write_enable;
  logic [DATA_W-1:0] memory_address;
  logic [DATA_W-1:0] memory_write_data;
  logic [DATA_W-1:0] memory_read_data;
  logic              busy;

  modport master (
    output a_request, a_write_enable, a_address, a_write_data,
    input  a_ack, a_read_data,
    output b_request, b_write_enable, b_address, b_write_data,
    input  b_ack, b_read_data,
    input  memory_write_enable, memory_address, memory_write_data,
    output memory_read_data,
    input  busy
  );

  modport slave (
    input  a_request, a_write_enable, a_address, a_write_data,
    output a_ack, a_read_data,
    input  b_request, b_write_enable, b_address, b_write_data,
    output b_ack, b_read_data,
    output memory_write_enable, memory_address, memory_write_data,
    input  memory_read_data,
    output busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter giving two requesters (A = CPU, B = display/DMA)
// one-at-a-time access to a single shared memory with READ_LATENCY read delay.
// Ports: clock, reset (async, active-low), bus (memory_arbiter_if.slave) carrying
// both requester handshakes, the memory strobe/address/data and busy.
module memory_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  memory_arbiter_if.slave bus
);
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_b_q;   // last granted requester, also the in-flight winner
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] a_rd_q, b_rd_q;
  logic              mem_we_q, a_ack_q, b_ack_q, busy_q;
  logic              mem_we_d, a_ack_d, b_ack_d, busy_d;
  logic              pick_b_c, grant_c, capture_c;

  // B wins only if A is idle or A was served last.
  assign pick_b_c  = bus.b_request && (!bus.a_request || !last_b_q);
  assign grant_c   = (state_q == IDLE) && (bus.a_request || bus.b_request);
  assign capture_c = (state_q == WAIT) && (cnt_q == '0);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_c) state_d = ISSUE;
      ISSUE:   state_d = we_q ? ACK : WAIT;
      WAIT:    if (capture_c) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values, registered below so they line up with the state they belong to.
  always_comb begin
    mem_we_d = 1'b0;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    busy_d   = (state_d != IDLE);
    if (grant_c) mem_we_d = pick_b_c ? bus.b_write_enable : bus.a_write_enable;
    if (state_d == ACK) begin
      a_ack_d = !last_b_q;
      b_ack_d = last_b_q;
    end
  end

  // Grant latch, latency counter, read capture and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      a_rd_q   <= '0;
      b_rd_q   <= '0;
      mem_we_q <= 1'b0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (grant_c) begin
        last_b_q <= pick_b_c;
        we_q     <= pick_b_c ? bus.b_write_enable : bus.a_write_enable;
        addr_q   <= pick_b_c ? bus.b_address      : bus.a_address;
        wdata_q  <= pick_b_c ? bus.b_write_data   : bus.a_write_data;
      end
      if (state_q == ISSUE && !we_q)      cnt_q <= CNT_W'(READ_LATENCY - 1);
      else if (state_q == WAIT && !capture_c) cnt_q <= cnt_q - CNT_W'(1);
      if (capture_c) begin
        if (last_b_q) b_rd_q <= bus.memory_read_data;
        else          a_rd_q <= bus.memory_read_data;
      end
      mem_we_q <= mem_we_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.memory_write_enable = mem_we_q;
  assign bus.memory_address      = addr_q;
  assign bus.memory_write_data   = wdata_q;
  assign bus.a_ack               = a_ack_q;
  assign bus.b_ack               = b_ack_q;
  assign bus.a_read_data         = a_rd_q;
  assign bus.b_read_data         = b_rd_q;
  assign bus.busy                = busy_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance at READ_LATENCY=1 with a
// scoreboard of expected acks/read data, one at READ_LATENCY=3 for latency timing.
module tb_memory_arbiter;
  typedef struct packed {
    logic        is_b;
    logic        is_read;
    logic [15:0] rdata;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memory_arbiter_if bus1();
  memory_arbiter_if bus3();

  memory_arbiter #(.READ_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  memory_arbiter #(.READ_LATENCY(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  logic [15:0] exp_a_rd, exp_b_rd;
  int acks_seen = 0;

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return (a == 16'h0200) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  // Shared memory models: writes stored, reads delayed by READ_LATENCY stages.
  logic [15:0] mem1 [0:4095];
  bit          wr1  [0:4095];
  logic [15:0] pipe1;
  always @(posedge clock) begin
    if (bus1.memory_write_enable) begin
      mem1[bus1.memory_address[11:0]] <= bus1.memory_write_data;
      wr1[bus1.memory_address[11:0]]  <= 1'b1;
    end
    pipe1 <= wr1[bus1.memory_address[11:0]] ? mem1[bus1.memory_address[11:0]]
                                            : pattern(bus1.memory_address);
  end
  assign bus1.memory_read_data = pipe1;

  logic [15:0] pipe3 [0:2];
  always @(posedge clock) begin
    pipe3[0] <= pattern(bus3.memory_address);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.memory_read_data = pipe3[2];

  // Reference contents for expected read data.
  logic [15:0] ref_mem [0:4095];
  bit          ref_wr  [0:4095];
  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_wr[a[11:0]] ? ref_mem[a[11:0]] : pattern(a);
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_b, input logic is_read,
                      input logic [15:0] addr, input logic [15:0] wdata);
    exp_t e;
    if (!is_read) begin
      ref_mem[addr[11:0]] = wdata;
      ref_wr[addr[11:0]]  = 1'b1;
    end
    e.is_b    = is_b;
    e.is_read = is_read;
    e.rdata   = is_read ? ref_read(addr) : 16'h0000;
    sb.push_back(e);
  endtask

  // Per-cycle checks on the latency-1 instance.
  task automatic monitor1();
    exp_t e;
    chk1("ack_exclusive", bus1.a_ack & bus1.b_ack, 1'b0);
    if (bus1.a_ack || bus1.b_ack) begin
      acks_seen++;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected_ack: observed ack with %0d pending expected at least 1", sb.size());
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk1("ack_who_b", bus1.b_ack, e.is_b);
        if (e.is_read) begin
          if (e.is_b) exp_b_rd = e.rdata;
          else        exp_a_rd = e.rdata;
        end
      end
    end
    chk16("a_read_data", bus1.a_read_data, exp_a_rd);
    chk16("b_read_data", bus1.b_read_data, exp_b_rd);
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
    monitor1();
  endtask

  initial begin
    int cycles;
    reset = 1'b0;
    bus1.a_request = 0; bus1.a_write_enable = 0; bus1.a_address = 0; bus1.a_write_data = 0;
    bus1.b_request = 0; bus1.b_write_enable = 0; bus1.b_address = 0; bus1.b_write_data = 0;
    bus3.a_request = 0; bus3.a_write_enable = 0; bus3.a_address = 0; bus3.a_write_data = 0;
    bus3.b_request = 0; bus3.b_write_enable = 0; bus3.b_address = 0; bus3.b_write_data = 0;
    exp_a_rd = 16'h0000;
    exp_b_rd = 16'h0000;
    repeat (2) @(negedge clock);

    // Reset state
    chk1("rst_busy", bus1.busy, 1'b0);
    chk1("rst_mem_we", bus1.memory_write_enable, 1'b0);
    chk16("rst_addr", bus1.memory_address, 16'h0000);
    chk16("rst_wdata", bus1.memory_write_data, 16'h0000);
    chk1("rst_a_ack", bus1.a_ack, 1'b0);
    chk1("rst_b_ack", bus1.b_ack, 1'b0);
    monitor1();
    chk1("rst3_busy", bus3.busy, 1'b0);

    // Both requesting from reset release: A, B, A, B
    bus1.a_request = 1; bus1.a_address = 16'h0020;
    bus1.b_request = 1; bus1.b_address = 16'h0030;
    push(1'b0, 1'b1, 16'h0020, 16'h0); push(1'b1, 1'b1, 16'h0030, 16'h0);
    push(1'b0, 1'b1, 16'h0020, 16'h0); push(1'b1, 1'b1, 16'h0030, 16'h0);
    reset = 1'b1;
    cycles = 0;
    acks_seen = 0;
    while (acks_seen < 4 && cycles < 40) begin
      cyc();
      cycles++;
    end
    bus1.a_request = 0; bus1.b_request = 0;
    chk16("rr_cycles", 16'(cycles), 16'd15);
    chk16("rr_sb_empty", 16'(sb.size()), 16'd0);
    cyc();
    chk1("rr_idle", bus1.busy, 1'b0);

    // A write with address/data changed after grant
    bus1.a_request = 1; bus1.a_write_enable = 1; bus1.a_address = 16'h0010; bus1.a_write_data = 16'hBEEF;
    push(1'b0, 1'b0, 16'h0010, 16'hBEEF);
    cyc();
    chk1("wr_busy", bus1.busy, 1'b1);
    chk1("wr_we_issue", bus1.memory_write_enable, 1'b1);
    chk16("wr_addr", bus1.memory_address, 16'h0010);
    chk16("wr_data", bus1.memory_write_data, 16'hBEEF);
    chk1("wr_no_early_ack", bus1.a_ack, 1'b0);
    bus1.a_address = 16'hFFFF; bus1.a_write_data = 16'h0000; bus1.a_write_enable = 0;
    cyc();
    chk1("wr_ack", bus1.a_ack, 1'b1);
    chk1("wr_we_ack", bus1.memory_write_enable, 1'b0);
    chk16("wr_addr_held", bus1.memory_address, 16'h0010);
    bus1.a_request = 0;
    cyc();
    chk1("wr_idle_busy", bus1.busy, 1'b0);
    chk1("wr_idle_ack", bus1.a_ack, 1'b0);
    chk16("wr_addr_idle", bus1.memory_address, 16'h0010);

    // B read of 0x0200
    bus1.b_request = 1; bus1.b_write_enable = 0; bus1.b_address = 16'h0200;
    push(1'b1, 1'b1, 16'h0200, 16'h0);
    cyc();
    chk1("brd_we_issue", bus1.memory_write_enable, 1'b0);
    chk16("brd_addr", bus1.memory_address, 16'h0200);
    cyc();
    chk1("brd_we_wait", bus1.memory_write_enable, 1'b0);
    chk1("brd_no_early_ack", bus1.b_ack, 1'b0);
    cyc();
    chk1("brd_ack", bus1.b_ack, 1'b1);
    chk1("brd_we_ack", bus1.memory_write_enable, 1'b0);
    bus1.b_request = 0;
    cyc();

    // B write alone after B was last granted
    bus1.b_request = 1; bus1.b_write_enable = 1; bus1.b_address = 16'h0300; bus1.b_write_data = 16'hCAFE;
    push(1'b1, 1'b0, 16'h0300, 16'hCAFE);
    cyc();
    chk16("bwr_addr", bus1.memory_address, 16'h0300);
    chk1("bwr_we", bus1.memory_write_enable, 1'b1);
    cyc();
    chk1("bwr_ack", bus1.b_ack, 1'b1);
    bus1.b_request = 0;
    cyc();

    // A read back of the earlier write
    bus1.a_request = 1; bus1.a_write_enable = 0; bus1.a_address = 16'h0010;
    push(1'b0, 1'b1, 16'h0010, 16'h0);
    cyc(); cyc(); cyc();
    chk1("ard_ack", bus1.a_ack, 1'b1);
    bus1.a_request = 0;
    cyc();

    // Request held past ACK starts a second transaction
    bus1.a_request = 1; bus1.a_write_enable = 1; bus1.a_address = 16'h0050; bus1.a_write_data = 16'h1111;
    push(1'b0, 1'b0, 16'h0050, 16'h1111);
    push(1'b0, 1'b0, 16'h0050, 16'h1111);
    cyc(); cyc();
    chk1("held_ack1", bus1.a_ack, 1'b1);
    cyc();
    chk1("held_idle", bus1.busy, 1'b0);
    cyc();
    chk1("held_regrant", bus1.memory_write_enable, 1'b1);
    bus1.a_request = 0;
    cyc();
    chk1("held_ack2", bus1.a_ack, 1'b1);
    cyc();

    // Reset during WAIT of an A read, then a lone B request is served
    bus1.a_request = 1; bus1.a_write_enable = 0; bus1.a_address = 16'h0060;
    push(1'b0, 1'b1, 16'h0060, 16'h0);
    cyc(); cyc();
    reset = 1'b0;
    bus1.a_request = 0;
    bus1.b_request = 1; bus1.b_write_enable = 0; bus1.b_address = 16'h0300;
    #1;
    sb.delete();
    exp_a_rd = 16'h0000;
    exp_b_rd = 16'h0000;
    chk1("abort_busy", bus1.busy, 1'b0);
    chk1("abort_we", bus1.memory_write_enable, 1'b0);
    chk16("abort_addr", bus1.memory_address, 16'h0000);
    chk16("abort_wdata", bus1.memory_write_data, 16'h0000);
    chk16("abort_a_rd", bus1.a_read_data, 16'h0000);
    cyc();
    chk1("abort_no_ack", bus1.a_ack, 1'b0);
    push(1'b1, 1'b1, 16'h0300, 16'h0);
    reset = 1'b1;
    cyc();
    chk1("post_rst_busy", bus1.busy, 1'b1);
    chk16("post_rst_addr", bus1.memory_address, 16'h0300);
    cyc(); cyc();
    chk1("post_rst_b_ack", bus1.b_ack, 1'b1);
    bus1.b_request = 0;
    cyc();
    chk16("final_sb_empty", 16'(sb.size()), 16'd0);

    // READ_LATENCY=3 read: three WAIT cycles, ack in the sixth cycle
    bus3.a_request = 1; bus3.a_write_enable = 0; bus3.a_address = 16'h0040;
    @(posedge clock); @(negedge clock);
    chk1("rl3_busy", bus3.busy, 1'b1);
    chk16("rl3_addr_issue", bus3.memory_address, 16'h0040);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); @(negedge clock);
      chk16("rl3_addr_wait", bus3.memory_address, 16'h0040);
      chk1("rl3_no_early_ack", bus3.a_ack, 1'b0);
      chk1("rl3_we", bus3.memory_write_enable, 1'b0);
    end
    @(posedge clock); @(negedge clock);
    chk1("rl3_ack", bus3.a_ack, 1'b1);
    chk16("rl3_rdata", bus3.a_read_data, pattern(16'h0040));
    chk16("rl3_b_rd", bus3.b_read_data, 16'h0000);
    bus3.a_request = 0;
    @(posedge clock); @(negedge clock);
    chk1("rl3_idle", bus3.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 1, meaning the number of cycles from mem_address presentation to valid memory_read_data (legal 1..3).
REQ-002 clock  input  1  The single clock; all state updates on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset (reset=0 resets the block immediately, independent of clock).
REQ-004 a_request  input  1  Requester A (CPU) transaction request; held high until a_ack.
REQ-005 a_write_enable  input  1  Requester A: 1=write, 0=read.
REQ-006 a_address  input  16  Requester A word address.
REQ-007 a_write_data  input  16  Requester A write data.
REQ-008 a_ack  output  1  One-cycle pulse: A's transaction complete.
REQ-009 a_read_data  output  16  A's last read result, held until A's next read completes.
REQ-010 b_request, b_write_enable, b_address, b_write_data, b_ack, b_read_data SHALL mirror REQ-004..REQ-009 for requester B (display/DMA).
REQ-011 memory_write_enable  output  1  Single-cycle write strobe to the shared memory.
REQ-012 memory_address  output  16  Shared memory address.
REQ-013 memory_write_data  output  16  Shared memory write data.
REQ-014 memory_read_data  input  16  Shared memory read data, valid READ_LATENCY cycles after address issue.
REQ-015 busy  output  1  High in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, ACK; exactly one transaction in flight at a time.
REQ-017 IDLE: if any request is high at the clock edge, the winner's write_enable/address/write_data SHALL be latched into internal registers and state -> ISSUE; otherwise stay IDLE.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; with one request high, it wins regardless of history.
REQ-019 The last-granted register SHALL reset to B so A wins the first simultaneous request.
REQ-020 ISSUE (exactly one cycle): memory_address/memory_write_data driven from latched registers; memory_write_enable = latched write_enable.
REQ-021 From ISSUE: a write SHALL go to ACK; a read SHALL go to WAIT with a counter loaded to READ_LATENCY-1.
REQ-022 WAIT: counter decrements each cycle; in the cycle memory_read_data is valid (READ_LATENCY cycles after the ISSUE cycle, counter = 0), it SHALL be captured into the winner's read_data register and state -> ACK.
REQ-023 READ_LATENCY=1: WAIT lasts one cycle (capture cycle); write transaction total = 3 cycles IDLE->ISSUE->ACK->IDLE; read = 4 cycles.
REQ-024 ACK (one cycle): winner's ack SHALL be 1, the other ack 0; state -> IDLE unconditionally; requests are ignored during ACK.
REQ-025 A request still high in the IDLE cycle after ACK SHALL be treated as a new transaction.
REQ-026 memory_write_enable SHALL be 0 in IDLE, WAIT, ACK and in ISSUE for reads.
REQ-027 memory_address/memory_write_data SHALL hold the latched values in all states after ISSUE until the next grant (stable address throughout WAIT).
REQ-028 The non-winner's read_data SHALL never change during another requester's transaction; write transactions SHALL not alter either read_data.
REQ-029 Request inputs changing after the grant edge SHALL not affect the in-flight transaction.
REQ-030 a_ack and b_ack SHALL never be high in the same cycle.

Reset
REQ-031 While reset=0: state=IDLE, counter=0, last-granted=B, latched registers=0, memory_write_enable=0, memory_address=0, memory_write_data=0, a_ack=b_ack=0, a_read_data=b_read_data=0, busy=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no ack and no further memory write; first grant after release follows REQ-017/REQ-019.

Verification
REQ-033 A write only: a_request=1, a_write_enable=1, a_address=0x0010, a_write_data=0xBEEF -> one-cycle memory_write_enable with address 0x0010/data 0xBEEF, a_ack 2 cycles after grant edge.
REQ-034 B read, READ_LATENCY=1, memory returns 0x1234 for 0x0200 -> b_read_data=0x1234 at b_ack, a_read_data unchanged, memory_write_enable never high.
REQ-035 Both request continuously from reset release -> grants A,B,A,B...; acks alternate, never coincide.
REQ-036 READ_LATENCY=3 read -> WAIT lasts 3 cycles, memory_address stable throughout, ack at cycle 6 of the transaction.
REQ-037 reset driven low during WAIT of an A read -> outputs per REQ-031 immediately, no a_ack; after release a pending B request is served first only if A is not requesting.
